// File: rtl/odt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : odt_pkg
//  Description : Shared types and constants for the ODT console port arbiter:
//                FSM state encoding, grant tracking, default timing values
//                and the DLART register addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
package odt_pkg;

    // Handshake sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_SETUP = 3'd1,
        ST_TX_STB   = 3'd2,
        ST_TX_REL   = 3'd3,
        ST_RX_STB   = 3'd4,
        ST_RX_REL   = 3'd5
    } odt_state_e;

    // Which path won the most recent arbitration
    typedef enum logic {
        GRANT_TX = 1'b0,
        GRANT_RX = 1'b1
    } odt_grant_e;

    // Default synchronizer depth and handshake timeout (clk cycles)
    localparam int          c_SYNC_STAGES_DEF = 2;
    localparam logic [15:0] c_TIMEOUT_DEF     = 16'd50000;

    // DLART register addresses (22-bit physical, octal)
    localparam logic [21:0] c_RCSR_ADDR = 22'o17777560;
    localparam logic [21:0] c_RBUF_ADDR = 22'o17777562;
    localparam logic [21:0] c_XCSR_ADDR = 22'o17777564;
    localparam logic [21:0] c_XBUF_ADDR = 22'o17777566;

endpackage
`default_nettype wire

// File: rtl/odt_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : odt_port_arbiter_if
//  Description : Bundles the CPU-side console register signals and the
//                host-side ODT handshake/data bus of the port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface odt_port_arbiter_if;

    // CPU / register side
    logic       clear;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ack;

    // Host handshake side
    logic       rrdy;
    logic       rstb;
    logic       wrdy;
    logic       wstb;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;

    // Sticky error flags
    logic       tx_overrun;
    logic       hs_timeout;

    // Arbiter side
    modport slave (
        input  clear, tx_valid, tx_data, rx_ack, rrdy, wrdy, ad_in,
        output tx_ready, rx_valid, rx_data, rstb, wstb, ad_out, ad_oe,
        output tx_overrun, hs_timeout
    );

    // Environment side (CPU model plus host)
    modport master (
        output clear, tx_valid, tx_data, rx_ack, rrdy, wrdy, ad_in,
        input  tx_ready, rx_valid, rx_data, rstb, wstb, ad_out, ad_oe,
        input  tx_overrun, hs_timeout
    );

endinterface
`default_nettype wire

// File: rtl/odt_sync.sv
`default_nettype none
// ============================================================================
//  Module      : odt_sync
//  Description : Multi-flop synchronizer for an asynchronous host ready line.
//                Flops clear asynchronously on reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module odt_sync #(
    parameter int DEPTH = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_d,
    output logic      o_q
);

    logic [DEPTH-1:0] r_sync;

    generate
        if (DEPTH == 1) begin : g_single
            // Single-stage capture of the asynchronous input
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sync <= 1'b0;
                else        r_sync <= i_d;
            end
        end else begin : g_chain
            // Shift the asynchronous input through the flop chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sync <= '0;
                else        r_sync <= {r_sync[DEPTH-2:0], i_d};
            end
        end
    endgenerate

    assign o_q = r_sync[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/odt_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : odt_port_arbiter
//  Description : Arbitrates the shared ODT data bus between the console TX
//                path (host reads XBUF byte via rrdy/rstb) and the RX path
//                (host writes RBUF byte via wrdy/wstb), round-robin on ties,
//                with per-phase handshake timeout and sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module odt_port_arbiter
    import odt_pkg::*;
#(
    parameter int          SYNC_STAGES = c_SYNC_STAGES_DEF,
    parameter logic [15:0] TIMEOUT     = c_TIMEOUT_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    odt_port_arbiter_if.slave  bus
);

    odt_state_e  r_state;
    odt_state_e  w_state_nxt;
    odt_grant_e  r_last_grant;

    logic        w_rrdy_s;
    logic        w_wrdy_s;

    logic        r_tx_ready;
    logic [7:0]  r_tx_hold;
    logic        r_tx_overrun;
    logic        r_rx_valid;
    logic [7:0]  r_rx_data;
    logic        r_hs_timeout;
    logic [15:0] r_cnt;

    logic        w_tx_req;
    logic        w_rx_req;
    logic        w_grant_tx;
    logic        w_grant_rx;
    logic        w_abort;
    logic        w_rstb;
    logic        w_wstb;
    logic        w_ad_oe;
    logic        w_cnt_exp;
    logic        w_stb_entry;
    logic        w_rx_capture;

    odt_sync #(.DEPTH(SYNC_STAGES)) u_sync_rrdy (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.rrdy),
        .o_q   (w_rrdy_s)
    );

    odt_sync #(.DEPTH(SYNC_STAGES)) u_sync_wrdy (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.wrdy),
        .o_q   (w_wrdy_s)
    );

    assign w_tx_req     = !r_tx_ready && w_rrdy_s;
    assign w_rx_req     = w_wrdy_s && !r_rx_valid;
    // The counter starts at 0 in the first strobe cycle, so the phase lasts
    // exactly TIMEOUT cycles before an abort.
    assign w_cnt_exp    = (r_cnt == (TIMEOUT - 16'd1));
    assign w_stb_entry  = ((w_state_nxt == ST_TX_STB) && (r_state != ST_TX_STB)) ||
                          ((w_state_nxt == ST_RX_STB) && (r_state != ST_RX_STB));
    assign w_rx_capture = (r_state == ST_RX_STB) && (r_cnt == 16'd0);

    // Next-state, grant and bus-strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_grant_tx  = 1'b0;
        w_grant_rx  = 1'b0;
        w_abort     = 1'b0;
        w_rstb      = 1'b0;
        w_wstb      = 1'b0;
        w_ad_oe     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tx_req && (!w_rx_req || (r_last_grant == GRANT_RX))) begin
                    w_grant_tx  = 1'b1;
                    w_state_nxt = ST_TX_SETUP;
                end else if (w_rx_req) begin
                    w_grant_rx  = 1'b1;
                    w_state_nxt = ST_RX_STB;
                end
            end
            ST_TX_SETUP: begin
                w_ad_oe     = 1'b1;
                w_state_nxt = ST_TX_STB;
            end
            ST_TX_STB: begin
                w_rstb  = 1'b1;
                w_ad_oe = 1'b1;
                if (!w_rrdy_s) begin
                    w_state_nxt = ST_TX_REL;
                end else if (w_cnt_exp) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TX_REL: begin
                w_state_nxt = ST_IDLE;
            end
            ST_RX_STB: begin
                w_wstb = 1'b1;
                if (!w_wrdy_s) begin
                    w_state_nxt = ST_RX_REL;
                end else if (w_cnt_exp) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RX_REL: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; clear forces IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_state <= ST_IDLE;
        else if (bus.clear) r_state <= ST_IDLE;
        else                r_state <= w_state_nxt;
    end

    // Round-robin memory: RX after reset so TX wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       r_last_grant <= GRANT_RX;
        else if (!bus.clear && w_grant_tx) r_last_grant <= GRANT_TX;
        else if (!bus.clear && w_grant_rx) r_last_grant <= GRANT_RX;
    end

    // Strobe-phase cycle counter, restarted on every strobe entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                             r_cnt <= 16'd0;
        else if (bus.clear || w_stb_entry)                      r_cnt <= 16'd0;
        else if (r_state == ST_TX_STB || r_state == ST_RX_STB)  r_cnt <= r_cnt + 16'd1;
    end

    // TX holding register, empty flag and overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_ready   <= 1'b1;
            r_tx_hold    <= 8'h00;
            r_tx_overrun <= 1'b0;
        end else if (bus.clear) begin
            r_tx_ready   <= 1'b1;
            r_tx_overrun <= 1'b0;
        end else begin
            if (bus.tx_valid && r_tx_ready) begin
                r_tx_hold  <= bus.tx_data;
                r_tx_ready <= 1'b0;
            end else if (bus.tx_valid) begin
                r_tx_overrun <= 1'b1;
            end
            if (r_state == ST_TX_REL) begin
                r_tx_ready <= 1'b1;
            end
        end
    end

    // RX byte capture on the first RX strobe cycle; capture beats rx_ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
        end else if (bus.clear) begin
            r_rx_valid <= 1'b0;
        end else if (w_rx_capture) begin
            r_rx_data  <= bus.ad_in;
            r_rx_valid <= 1'b1;
        end else if (bus.rx_ack) begin
            r_rx_valid <= 1'b0;
        end
    end

    // Sticky handshake-timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_hs_timeout <= 1'b0;
        else if (bus.clear) r_hs_timeout <= 1'b0;
        else if (w_abort)   r_hs_timeout <= 1'b1;
    end

    // Strobes decode straight from the state register so reset drops them
    // immediately, and ad_out is only non-zero while the bus is driven.
    assign bus.rstb       = w_rstb;
    assign bus.wstb       = w_wstb;
    assign bus.ad_oe      = w_ad_oe;
    assign bus.ad_out     = w_ad_oe ? r_tx_hold : 8'h00;
    assign bus.tx_ready   = r_tx_ready;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.rx_data    = r_rx_data;
    assign bus.tx_overrun = r_tx_overrun;
    assign bus.hs_timeout = r_hs_timeout;

endmodule
`default_nettype wire

// File: tb/tb_odt_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_odt_port_arbiter
//  Description : Directed self-checking bench for odt_port_arbiter
//                (SYNC_STAGES=2, TIMEOUT=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_odt_port_arbiter;

    localparam int c_SEL_RSTB  = 0;
    localparam int c_SEL_WSTB  = 1;
    localparam int c_SEL_ADOE  = 2;
    localparam int c_SEL_TXRDY = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   n;

    always #5 clk = ~clk;

    odt_port_arbiter_if bus ();

    odt_port_arbiter #(
        .SYNC_STAGES (2),
        .TIMEOUT     (16'd16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            c_SEL_RSTB:  return bus.rstb;
            c_SEL_WSTB:  return bus.wstb;
            c_SEL_ADOE:  return bus.ad_oe;
            default:     return bus.tx_ready;
        endcase
    endfunction

    // Bounded wait for a DUT output; an expired bound shows up as a failed check
    task automatic wait_sig(input string tag, input int sel, input logic v,
                            input int maxc, output int cnt);
        cnt = 0;
        while (sig(sel) !== v && cnt < maxc) begin
            tick();
            cnt++;
        end
        chk(tag, sig(sel), v);
    endtask

    // Bus drive and write strobe must never overlap
    always @(negedge clk) begin
        total++;
        assert ((bus.ad_oe & bus.wstb) === 1'b0) else begin
            bad++;
            $error("FAIL oe_wstb_excl observed=1 expected=0");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clear = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.rx_ack = 1'b0;
        bus.rrdy  = 1'b0; bus.wrdy     = 1'b0; bus.ad_in   = 8'h00;

        // ---- reset state ----
        repeat (2) tick();
        chk("rst_tx_ready", bus.tx_ready, 1'b1);
        chk("rst_outs", {bus.rstb, bus.wstb, bus.ad_oe, bus.tx_overrun, bus.hs_timeout, bus.rx_valid}, 6'b0);
        chk("rst_ad_out", bus.ad_out, 8'h00);
        chk("rst_rx_data", bus.rx_data, 8'h00);
        rst_n = 1'b1;
        tick();

        // ---- TX with rrdy already high ----
        bus.rrdy = 1'b1;
        repeat (3) tick();
        bus.tx_valid = 1'b1; bus.tx_data = 8'h41;
        tick();
        bus.tx_valid = 1'b0;
        chk("tx1_busy", bus.tx_ready, 1'b0);
        tick();
        chk("tx1_setup_oe", bus.ad_oe, 1'b1);
        chk("tx1_setup_data", bus.ad_out, 8'h41);
        chk("tx1_setup_rstb", bus.rstb, 1'b0);
        tick();
        chk("tx1_stb_rstb", bus.rstb, 1'b1);
        chk("tx1_stb_oe", bus.ad_oe, 1'b1);
        bus.rrdy = 1'b0;
        wait_sig("tx1_rstb_fall", c_SEL_RSTB, 1'b0, 3, n);
        chk("tx1_rel_oe", bus.ad_oe, 1'b0);
        tick();
        chk("tx1_ready", bus.tx_ready, 1'b1);

        // ---- RX, with rx_ack colliding with the capture cycle ----
        bus.ad_in = 8'h0D; bus.wrdy = 1'b1;
        repeat (2) tick();
        chk("rx1_pre_wstb", bus.wstb, 1'b0);
        tick();
        chk("rx1_wstb", bus.wstb, 1'b1);
        chk("rx1_oe", bus.ad_oe, 1'b0);
        chk("rx1_not_yet", bus.rx_valid, 1'b0);
        bus.rx_ack = 1'b1;
        tick();
        bus.rx_ack = 1'b0;
        chk("rx1_valid", bus.rx_valid, 1'b1);
        chk("rx1_data", bus.rx_data, 8'h0D);
        bus.wrdy = 1'b0;
        wait_sig("rx1_wstb_fall", c_SEL_WSTB, 1'b0, 3, n);
        tick();
        chk("rx1_held", bus.rx_valid, 1'b1);
        bus.rx_ack = 1'b1;
        tick();
        bus.rx_ack = 1'b0;
        chk("rx1_acked", bus.rx_valid, 1'b0);

        // ---- TX overrun: second byte while first pending ----
        bus.tx_valid = 1'b1; bus.tx_data = 8'h41;
        tick();
        bus.tx_data = 8'h42;
        tick();
        bus.tx_valid = 1'b0;
        chk("ovr_flag", bus.tx_overrun, 1'b1);
        chk("ovr_busy", bus.tx_ready, 1'b0);
        bus.rrdy = 1'b1;
        wait_sig("ovr_oe", c_SEL_ADOE, 1'b1, 6, n);
        chk("ovr_data", bus.ad_out, 8'h41);
        wait_sig("ovr_rstb", c_SEL_RSTB, 1'b1, 2, n);
        bus.rrdy = 1'b0;
        wait_sig("ovr_ready", c_SEL_TXRDY, 1'b1, 6, n);
        chk("ovr_sticky", bus.tx_overrun, 1'b1);

        // ---- handshake timeout with rrdy held high, then retry ----
        bus.tx_valid = 1'b1; bus.tx_data = 8'h55;
        tick();
        bus.tx_valid = 1'b0;
        bus.rrdy = 1'b1;
        wait_sig("to_rstb", c_SEL_RSTB, 1'b1, 6, n);
        n = 0;
        while (bus.rstb === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("to_stb_cycles", n, 16);
        chk("to_flag", bus.hs_timeout, 1'b1);
        chk("to_keep_busy", bus.tx_ready, 1'b0);
        chk("to_oe_drop", bus.ad_oe, 1'b0);
        tick();
        chk("to_retry_oe", bus.ad_oe, 1'b1);
        chk("to_retry_data", bus.ad_out, 8'h55);
        bus.rrdy = 1'b0;
        wait_sig("to_retry_done", c_SEL_TXRDY, 1'b1, 8, n);
        chk("to_sticky", bus.hs_timeout, 1'b1);

        // ---- clear during TX_STB, overriding a simultaneous tx_valid ----
        bus.tx_valid = 1'b1; bus.tx_data = 8'h66;
        tick();
        bus.tx_valid = 1'b0;
        bus.rrdy = 1'b1;
        wait_sig("clr_rstb", c_SEL_RSTB, 1'b1, 6, n);
        bus.clear = 1'b1; bus.tx_valid = 1'b1; bus.tx_data = 8'h77;
        tick();
        bus.clear = 1'b0; bus.tx_valid = 1'b0;
        chk("clr_rstb_low", bus.rstb, 1'b0);
        chk("clr_oe_low", bus.ad_oe, 1'b0);
        chk("clr_ready", bus.tx_ready, 1'b1);
        chk("clr_flags", {bus.tx_overrun, bus.hs_timeout}, 2'b00);
        tick();
        chk("clr_idle", {bus.rstb, bus.ad_oe}, 2'b00);

        // ---- asynchronous reset during TX_STB ----
        bus.tx_valid = 1'b1; bus.tx_data = 8'h11;
        tick();
        bus.tx_valid = 1'b0;
        wait_sig("rst_mid_rstb", c_SEL_RSTB, 1'b1, 6, n);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_drop", {bus.rstb, bus.wstb, bus.ad_oe}, 3'b000);
        chk("rst_mid_ready", bus.tx_ready, 1'b1);
        bus.rrdy = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // ---- ties: first after reset goes to TX, the next to RX ----
        bus.tx_valid = 1'b1; bus.tx_data = 8'hA1;
        tick();
        bus.tx_valid = 1'b0;
        bus.ad_in = 8'h5A;
        bus.rrdy = 1'b1; bus.wrdy = 1'b1;
        repeat (3) tick();
        chk("tie1_oe", bus.ad_oe, 1'b1);
        chk("tie1_data", bus.ad_out, 8'hA1);
        chk("tie1_wstb", bus.wstb, 1'b0);
        tick();
        chk("tie1_rstb", bus.rstb, 1'b1);
        bus.rrdy = 1'b0; bus.wrdy = 1'b0;
        wait_sig("tie1_done", c_SEL_TXRDY, 1'b1, 6, n);
        chk("tie1_no_rx", bus.wstb, 1'b0);

        bus.tx_valid = 1'b1; bus.tx_data = 8'hB2;
        tick();
        bus.tx_valid = 1'b0;
        bus.rrdy = 1'b1; bus.wrdy = 1'b1;
        repeat (3) tick();
        chk("tie2_wstb", bus.wstb, 1'b1);
        chk("tie2_oe", bus.ad_oe, 1'b0);
        tick();
        chk("tie2_rx_valid", bus.rx_valid, 1'b1);
        chk("tie2_rx_data", bus.rx_data, 8'h5A);
        bus.wrdy = 1'b0;
        wait_sig("tie2_tx_after", c_SEL_ADOE, 1'b1, 8, n);
        chk("tie2_tx_data", bus.ad_out, 8'hB2);
        bus.rrdy = 1'b0;
        wait_sig("tie2_tx_done", c_SEL_TXRDY, 1'b1, 8, n);
        bus.rx_ack = 1'b1;
        tick();
        bus.rx_ack = 1'b0;
        chk("tie2_ack", bus.rx_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/odt_port_arbiter.md
ODT_PORT_ARBITER -- requirements
Module: odt_port_arbiter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for rrdy and wrdy.
REQ-002 SHALL have parameter TIMEOUT, default 16'd50000: clk cycles allowed for a host handshake phase.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on posedge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port clear, input, 1: synchronous console clear (GP code 014 decode).
REQ-006 SHALL have ports tx_valid (input, 1) and tx_data (input, 8): the CPU has written an XBUF byte.
REQ-007 SHALL have port tx_ready, output, 1: TX holding register empty; feeds XCSR bit 7.
REQ-008 SHALL have ports rx_valid (output, 1) and rx_data (output, 8): an RX byte is held; feeds RCSR bit 7 and RBUF.
REQ-009 SHALL have port rx_ack, input, 1: the CPU has read RBUF.
REQ-010 SHALL have ports rrdy (input, 1) and rstb (output, 1): host-read handshake.
REQ-011 SHALL have ports wrdy (input, 1) and wstb (output, 1): host-write handshake.
REQ-012 SHALL have ports ad_in (input, 8), ad_out (output, 8) and ad_oe (output, 1): the shared ODT data bus, split into input, output and output enable.
REQ-013 SHALL have ports tx_overrun (output, 1) and hs_timeout (output, 1): sticky error flags.

Function
REQ-014 SHALL pass rrdy and wrdy through SYNC_STAGES flops; rrdy_s and wrdy_s are the synchronized values, and all decisions SHALL use only these.
REQ-015 SHALL load tx_data into the TX holding register when tx_valid=1 and tx_ready=1; tx_ready SHALL go 0 on the next cycle.
REQ-016 SHALL ignore tx_valid while tx_ready=0 and set tx_overrun.
REQ-017 SHALL implement a state machine with states IDLE, TX_SETUP, TX_STB, TX_REL, RX_STB and RX_REL.
REQ-018 In IDLE, the TX request SHALL be tx_ready=0 AND rrdy_s=1.
REQ-019 In IDLE, the RX request SHALL be wrdy_s=1 AND rx_valid=0.
REQ-020 When only one request is active in IDLE, the FSM SHALL grant it.
REQ-021 When both requests are active in IDLE, the FSM SHALL grant the path not granted last (round-robin); after reset, TX SHALL win the first tie.
REQ-022 TX_SETUP SHALL set ad_oe=1 and ad_out=holding register, with rstb=0, for exactly 1 cycle, then go to TX_STB.
REQ-023 TX_STB SHALL set rstb=1 and ad_oe=1 until rrdy_s=0, then go to TX_REL.
REQ-024 TX_REL SHALL set rstb=0 and ad_oe=0 for 1 cycle, set tx_ready=1, and return to IDLE.
REQ-025 RX_STB SHALL set wstb=1 and ad_oe=0; on its first cycle it SHALL capture ad_in into rx_data and set rx_valid=1.
REQ-026 RX_STB SHALL remain until wrdy_s=0, then go to RX_REL.
REQ-027 RX_REL SHALL set wstb=0 for 1 cycle, then return to IDLE.
REQ-028 rx_ack=1 SHALL clear rx_valid on the next cycle; rx_ack in the same cycle as the RX_STB capture SHALL be ignored (the capture wins).
REQ-029 ad_oe SHALL be 1 only in TX_SETUP and TX_STB; ad_oe=1 and wstb=1 SHALL never occur together.
REQ-030 A cycle counter SHALL reset on each entry to TX_STB or RX_STB.
REQ-031 If the counter reaches TIMEOUT, the FSM SHALL abort to IDLE, drop rstb, wstb and ad_oe, and set hs_timeout.
REQ-032 An aborted TX SHALL keep its byte and tx_ready=0, and SHALL retry.
REQ-033 An aborted RX SHALL keep the byte already captured.
REQ-034 clear=1 SHALL, on the next edge, force IDLE, set rstb, wstb and ad_oe to 0, set tx_ready=1 and rx_valid=0, and clear both sticky flags; clear SHALL override every other input that cycle.
REQ-035 Latency SHALL be: tx_valid to rstb rise no more than SYNC_STAGES+2 cycles when rrdy is already high; wrdy rise to wstb rise = SYNC_STAGES+1 cycles.

Reset
REQ-036 rst_n=0 SHALL asynchronously force state IDLE and rstb=0, wstb=0, ad_oe=0, ad_out=0.
REQ-037 rst_n=0 SHALL asynchronously force tx_ready=1, rx_valid=0, rx_data=0, tx_overrun=0, hs_timeout=0.
REQ-038 rst_n=0 SHALL asynchronously clear the synchronizer flops and the counter, and set last-grant=RX.
REQ-039 rst_n asserted mid-handshake SHALL drop rstb and wstb immediately.

Structure
REQ-040 The state enum, the default SYNC_STAGES and TIMEOUT values, and the DLART register addresses (RCSR 17777560, RBUF 17777562, XCSR 17777564, XBUF 17777566 octal) SHALL reside in package odt_pkg.
REQ-041 The synchronizer SHALL be a sub-module odt_sync, parameterized by depth, instantiated once for rrdy and once for wrdy.

Verification
REQ-042 TX with rrdy=1: tx_data=8'h41 -> ad_out=8'h41 with ad_oe=1 one cycle before rstb rises; rrdy drop -> rstb=0 within SYNC_STAGES+1 cycles and tx_ready=1.
REQ-043 RX: ad_in=8'h0D with wrdy raised -> wstb=1 after 3 cycles, rx_data=8'h0D, rx_valid=1; rx_ack -> rx_valid=0.
REQ-044 Tie: TX pending and wrdy raised in the same cycle, repeated twice -> grants are TX then RX, and ad_oe never coincides with wstb.
REQ-045 Second tx_valid (8'h42) while 8'h41 is pending -> tx_overrun=1 and 8'h41 is transmitted.
REQ-046 Host holds rrdy=1 with TIMEOUT=16 -> abort after 16 cycles in TX_STB, hs_timeout=1; retry once rrdy re-rises.
REQ-047 clear, and separately rst_n, pulsed during TX_STB -> rstb=0, ad_oe=0, tx_ready=1, FSM in IDLE.
